// File: rtl/tdm_demux_pkg.sv
// Shared types for the TDM demultiplexer slice: channel count, slot index and FSM state.
package tdm_demux_pkg;

  localparam int NUM_CH = 4;

  typedef logic [1:0] slot_t;

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    RUN  = 1'b1
  } demux_state_t;

endpackage

// File: rtl/tdm_demux4_if.sv
// Serial-in / four-channel-out bundle for tdm_demux4.
// The sync_err signal exists only when TDM_DEMUX_SYNC_CHECK_EN is defined.
interface tdm_demux4_if #(
  parameter int WIDTH = 2
);
  logic             in_valid;
  logic             in_sync;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] y0;
  logic [WIDTH-1:0] y1;
  logic [WIDTH-1:0] y2;
  logic [WIDTH-1:0] y3;
  logic [3:0]       ch_valid;
  logic             frame_done;
  logic             locked;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
  logic             sync_err;

  modport master (
    output in_valid, in_sync, in_data,
    input  y0, y1, y2, y3, ch_valid, frame_done, locked, sync_err
  );
  modport slave (
    input  in_valid, in_sync, in_data,
    output y0, y1, y2, y3, ch_valid, frame_done, locked, sync_err
  );
`else
  modport master (
    output in_valid, in_sync, in_data,
    input  y0, y1, y2, y3, ch_valid, frame_done, locked
  );
  modport slave (
    input  in_valid, in_sync, in_data,
    output y0, y1, y2, y3, ch_valid, frame_done, locked
  );
`endif
endinterface

// File: rtl/tdm_demux4_slot_ctr.sv
// Two-bit slot counter: sync loads 1 (the word after slot 0), data words advance it mod 4.
module tdm_slot_ctr
  import tdm_demux_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  inc,
  input  logic  load_one,
  output slot_t slot,
  output logic  wrap
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (load_one) begin
      slot <= slot_t'(1);
    end else if (inc) begin
      slot <= slot + slot_t'(1);
    end
  end

  // A load always lands on slot 1, so it can never complete a frame.
  assign wrap = inc && !load_one && (slot == slot_t'(NUM_CH - 1));

endmodule

// File: rtl/tdm_demux4.sv
// Registered 1-to-4 TDM demultiplexer with sync-based slot alignment.
// Define TDM_DEMUX_SYNC_CHECK_EN to add the sync_err pulse on early sync.
//
// state | meaning
// HUNT  | waiting for a sync word; non-sync words are dropped
// RUN   | aligned; words routed by slot counter, sync realigns to slot 0
module tdm_demux4
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  tdm_demux4_if.slave  bus
);

  localparam logic [0:0] ST_HUNT = 1'(HUNT);
  localparam logic [0:0] ST_RUN  = 1'(RUN);

  logic [0:0]       state;
  slot_t            slot;
  logic             wrap;
  logic             take_sync;
  logic             take_data;
  logic             wr_en;
  slot_t            wr_idx;
  logic [WIDTH-1:0] y_q [NUM_CH];
  logic [NUM_CH-1:0] ch_valid_q;
  logic             frame_done_q;

  assign take_sync = bus.in_valid && bus.in_sync;
  assign take_data = bus.in_valid && !bus.in_sync && (state == ST_RUN);
  assign wr_en     = take_sync || take_data;
  assign wr_idx    = take_sync ? slot_t'(0) : slot;

  tdm_slot_ctr u_slot_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (take_data),
    .load_one (take_sync),
    .slot     (slot),
    .wrap     (wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_HUNT;
      ch_valid_q   <= '0;
      frame_done_q <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        y_q[k] <= '0;
      end
    end else begin
      ch_valid_q   <= '0;
      frame_done_q <= wrap;
      if (take_sync) begin
        state <= ST_RUN;
      end
      if (wr_en) begin
        y_q[wr_idx]        <= bus.in_data;
        ch_valid_q[wr_idx] <= 1'b1;
      end
    end
  end

`ifdef TDM_DEMUX_SYNC_CHECK_EN
  logic sync_err_q;

  // A sync while aligned at slot 0 is the normal frame start, not an error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_err_q <= 1'b0;
    end else begin
      sync_err_q <= take_sync && (state == ST_RUN) && (slot != slot_t'(0));
    end
  end

  assign bus.sync_err = sync_err_q;
`endif

  assign bus.y0         = y_q[0];
  assign bus.y1         = y_q[1];
  assign bus.y2         = y_q[2];
  assign bus.y3         = y_q[3];
  assign bus.ch_valid   = ch_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.locked     = (state == ST_RUN);

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4: stimulus queues expected strobes, a monitor checks them.
module tb_tdm_demux4;

  typedef struct {
    logic [1:0] ch;
    logic [1:0] data;
    logic       fd;
    logic       se;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t q[$];

  tdm_demux4_if #(.WIDTH(2)) bus ();

  tdm_demux4 #(.WIDTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ysel(input logic [1:0] ch);
    case (ch)
      2'd0:    return bus.y0;
      2'd1:    return bus.y1;
      2'd2:    return bus.y2;
      default: return bus.y3;
    endcase
  endfunction

  function automatic logic sync_err_now();
`ifdef TDM_DEMUX_SYNC_CHECK_EN
    return bus.sync_err;
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: every strobe the DUT presents must match the head of the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (bus.ch_valid != 4'b0 || bus.frame_done || sync_err_now())) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse ch_valid=%b frame_done=%b at %0t",
                   bus.ch_valid, bus.frame_done, $time);
        end else begin
          e = q.pop_front();
          chk("ch_valid", {28'b0, bus.ch_valid}, 32'(4'b0001 << e.ch));
          chk("y_data", {30'b0, ysel(e.ch)}, {30'b0, e.data});
          chk("frame_done", {31'b0, bus.frame_done}, {31'b0, e.fd});
`ifdef TDM_DEMUX_SYNC_CHECK_EN
          chk("sync_err", {31'b0, bus.sync_err}, {31'b0, e.se});
`endif
        end
      end
    end
  end

  task automatic word(input logic s, input logic [1:0] d, input bit push,
                      input logic [1:0] ch, input logic fd, input logic se);
    exp_t e;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_sync  = s;
    bus.in_data  = d;
    if (push) begin
      e.ch = ch; e.data = d; e.fd = fd; e.se = se;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_sync  = 1'b0;
      bus.in_data  = 2'b00;
    end
  endtask

  task automatic check_ys(input string name, input logic [7:0] exp);
    chk(name, {24'b0, bus.y3, bus.y2, bus.y1, bus.y0}, {24'b0, exp});
  endtask

  task automatic check_cleared(input string name);
    check_ys({name, "_y"}, 8'h00);
    chk({name, "_ch_valid"}, {28'b0, bus.ch_valid}, 32'd0);
    chk({name, "_frame_done"}, {31'b0, bus.frame_done}, 32'd0);
    chk({name, "_locked"}, {31'b0, bus.locked}, 32'd0);
`ifdef TDM_DEMUX_SYNC_CHECK_EN
    chk({name, "_sync_err"}, {31'b0, bus.sync_err}, 32'd0);
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.in_valid = 1'b0;
    bus.in_sync  = 1'b0;
    bus.in_data  = 2'b00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst_n = 1'b1;

    // HUNT drops non-sync words
    for (int i = 0; i < 3; i++) word(1'b0, 2'b11, 1'b0, 2'd0, 1'b0, 1'b0);
    idle(1);
    check_cleared("hunt");

    // full frame, back to back
    word(1'b1, 2'b00, 1'b1, 2'd0, 1'b0, 1'b0);
    word(1'b0, 2'b01, 1'b1, 2'd1, 1'b0, 1'b0);
    word(1'b0, 2'b10, 1'b1, 2'd2, 1'b0, 1'b0);
    word(1'b0, 2'b11, 1'b1, 2'd3, 1'b1, 1'b0);
    idle(1);
    check_ys("frame_y", 8'b11_10_01_00);
    chk("frame_locked", {31'b0, bus.locked}, 32'd1);

    // idle gap between slot 1 and slot 2
    word(1'b1, 2'b11, 1'b1, 2'd0, 1'b0, 1'b0);
    word(1'b0, 2'b10, 1'b1, 2'd1, 1'b0, 1'b0);
    idle(2);
    word(1'b0, 2'b01, 1'b1, 2'd2, 1'b0, 1'b0);
    word(1'b0, 2'b00, 1'b1, 2'd3, 1'b1, 1'b0);
    idle(1);
    check_ys("gap_y", 8'b00_01_10_11);

    // early sync realigns to slot 0, next data word lands in y1
    word(1'b1, 2'b00, 1'b1, 2'd0, 1'b0, 1'b0);
    word(1'b0, 2'b01, 1'b1, 2'd1, 1'b0, 1'b0);
    word(1'b1, 2'b10, 1'b1, 2'd0, 1'b0, 1'b1);
    word(1'b0, 2'b11, 1'b1, 2'd1, 1'b0, 1'b0);
    word(1'b0, 2'b00, 1'b1, 2'd2, 1'b0, 1'b0);
    word(1'b0, 2'b01, 1'b1, 2'd3, 1'b1, 1'b0);
    idle(1);
    check_ys("early_y", 8'b01_00_11_10);

    // two frames, second without sync: counter free-runs through the wrap
    word(1'b1, 2'b00, 1'b1, 2'd0, 1'b0, 1'b0);
    word(1'b0, 2'b01, 1'b1, 2'd1, 1'b0, 1'b0);
    word(1'b0, 2'b10, 1'b1, 2'd2, 1'b0, 1'b0);
    word(1'b0, 2'b11, 1'b1, 2'd3, 1'b1, 1'b0);
    word(1'b0, 2'b11, 1'b1, 2'd0, 1'b0, 1'b0);
    word(1'b0, 2'b10, 1'b1, 2'd1, 1'b0, 1'b0);
    word(1'b0, 2'b01, 1'b1, 2'd2, 1'b0, 1'b0);
    word(1'b0, 2'b00, 1'b1, 2'd3, 1'b1, 1'b0);
    idle(1);
    check_ys("wrap_y", 8'b00_01_10_11);

    // async reset mid-frame after slot 2
    word(1'b1, 2'b01, 1'b1, 2'd0, 1'b0, 1'b0);
    word(1'b0, 2'b10, 1'b1, 2'd1, 1'b0, 1'b0);
    word(1'b0, 2'b11, 1'b1, 2'd2, 1'b0, 1'b0);
    idle(1);
    #2 rst_n = 1'b0;
    #1 check_cleared("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    word(1'b0, 2'b11, 1'b0, 2'd0, 1'b0, 1'b0);
    idle(2);
    check_cleared("post_rst");

    idle(2);
    chk("queue_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
